// File: rtl/round_robin_bus_arbiter.sv
// Round-robin N:1 valid/ready arbiter with a one-deep registered output.
// Optional handshake counter enabled by ROUND_ROBIN_BUS_ARBITER_XFER_COUNT_EN.
module round_robin_bus_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int IDXW  = $clog2(N)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [N-1:0]         i_valid,
   output logic [N-1:0]         i_ready,
   input  logic [N*WIDTH-1:0]   i_data,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [WIDTH-1:0]     o_data,
`ifdef ROUND_ROBIN_BUS_ARBITER_XFER_COUNT_EN
   output logic [15:0]          o_xfer_count,
`endif
   output logic [IDXW-1:0]      o_grant
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [IDXW-1:0]  grant_q, grant_d;
   logic [IDXW-1:0]  ptr_q, ptr_d;

   logic             accept;
   logic             in_hs;
   logic             hi_ok, lo_ok;
   logic [IDXW-1:0]  hi_idx, lo_idx;
   logic             win_ok;
   logic [IDXW-1:0]  win_idx;
   logic [IDXW-1:0]  win_nxt;

   // Lowest requester at or above ptr, else lowest one below ptr.
   always_comb begin
      hi_ok  = 1'b0;
      lo_ok  = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_valid[k]) begin
            if (IDXW'(k) >= ptr_q) begin
               hi_ok  = 1'b1;
               hi_idx = IDXW'(k);
            end else begin
               lo_ok  = 1'b1;
               lo_idx = IDXW'(k);
            end
         end
      end
   end

   always_comb begin
      win_ok  = hi_ok | lo_ok;
      win_idx = hi_ok ? hi_idx : lo_idx;
      win_nxt = (win_idx == LAST) ? '0 : win_idx + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      i_ready = '0;
      accept  = (state_q == EMPTY) | o_ready;
      in_hs   = accept & win_ok & ~i_rst;

      if (in_hs) begin
         i_ready[win_idx] = 1'b1;
         data_d  = i_data[win_idx*WIDTH +: WIDTH];
         grant_d = win_idx;
         ptr_d   = win_nxt;
      end

      unique case (state_q)
         EMPTY: begin
            if (in_hs) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (o_ready && !in_hs) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign o_valid = (state_q == FULL);
   assign o_data  = data_q;
   assign o_grant = grant_q;

`ifdef ROUND_ROBIN_BUS_ARBITER_XFER_COUNT_EN
   logic [15:0] xfer_count_q, xfer_count_d;

   always_comb begin
      xfer_count_d = xfer_count_q;
      if (o_valid && o_ready) begin
         xfer_count_d = xfer_count_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         xfer_count_q <= '0;
      end else begin
         xfer_count_q <= xfer_count_d;
      end
   end

   assign o_xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_round_robin_bus_arbiter.sv
// Randomized bench for round_robin_bus_arbiter against a behavioural model.
// Directed scenarios first, then random traffic with a payload scoreboard.
module tb_round_robin_bus_arbiter;

   localparam int N    = 4;
   localparam int W    = 8;
   localparam int IDXW = $clog2(N);

   logic              clk;
   logic              i_rst;
   logic [N-1:0]      i_valid;
   logic [N-1:0]      i_ready;
   logic [N*W-1:0]    i_data;
   logic              o_valid;
   logic              o_ready;
   logic [W-1:0]      o_data;
   logic [IDXW-1:0]   o_grant;
`ifdef ROUND_ROBIN_BUS_ARBITER_XFER_COUNT_EN
   logic [15:0]       o_xfer_count;
`endif

   round_robin_bus_arbiter #(.N(N), .WIDTH(W)) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .i_ready      (i_ready),
      .i_data       (i_data),
      .o_valid      (o_valid),
      .o_ready      (o_ready),
      .o_data       (o_data),
`ifdef ROUND_ROBIN_BUS_ARBITER_XFER_COUNT_EN
      .o_xfer_count (o_xfer_count),
`endif
      .o_grant      (o_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Model state: ptr as a plain integer, one-entry output register.
   int          m_ptr;
   bit          m_full;
   int          m_data;
   int          m_grant;
   int          m_cnt;
   int          sb[$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int winner(input logic [N-1:0] v, input int p);
      for (int off = 0; off < N; off++) begin
         if (v[(p + off) % N]) return (p + off) % N;
      end
      return -1;
   endfunction

   function automatic logic [N*W-1:0] rand_data();
      logic [N*W-1:0] d;
      for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
      return d;
   endfunction

   // Drive one cycle (entered just after a negedge), check, advance.
   task automatic step(input logic [N-1:0] v, input logic rdy,
                       input logic rst, input logic [N*W-1:0] d);
      int  w;
      bit  acc;
      logic [N-1:0] er;
      i_valid = v;
      o_ready = rdy;
      i_rst   = rst;
      i_data  = d;
      #1;
      w   = winner(v, m_ptr);
      acc = !m_full || rdy;
      er  = '0;
      if (!rst && acc && w >= 0) er[w] = 1'b1;
      check("i_ready", 32'(i_ready), 32'(er));
      if (!rst && m_full && rdy) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(o_data), 32'hFFFF_FFFF);
         end else begin
            check("sb_data", 32'(o_data), 32'(sb.pop_front()));
         end
      end
      @(posedge clk);
      if (rst) begin
         m_ptr = 0; m_full = 0; m_data = 0; m_grant = 0; m_cnt = 0;
         sb.delete();
      end else begin
         if (m_full && rdy) m_cnt = (m_cnt + 1) % 65536;
         if (acc && w >= 0) begin
            m_data  = int'(d[w*W +: W]);
            m_grant = w;
            m_full  = 1;
            m_ptr   = (w + 1) % N;
            sb.push_back(m_data);
         end else if (m_full && rdy) begin
            m_full = 0;
         end
      end
      #1;
      check("o_valid", 32'(o_valid), 32'(m_full));
      check("o_data", 32'(o_data), 32'(m_data));
      check("o_grant", 32'(o_grant), 32'(m_grant));
`ifdef ROUND_ROBIN_BUS_ARBITER_XFER_COUNT_EN
      check("xfer_count", 32'(o_xfer_count), 32'(m_cnt));
`endif
      @(negedge clk);
   endtask

   initial begin
      logic [N*W-1:0] d;
      logic [W-1:0]   held;
      int             seq[5] = '{0, 1, 2, 3, 0};
      m_ptr = 0; m_full = 0; m_data = 0; m_grant = 0; m_cnt = 0;
      i_rst = 1'b1; i_valid = '0; o_ready = 1'b0; i_data = '0;
      @(negedge clk);

      // Reset with requests pending: no ready, register cleared
      step(4'b1111, 1'b1, 1'b1, rand_data());
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_grant", 32'(o_grant), 32'd0);

      // All requesting, sink always ready: grants rotate 0,1,2,3,0
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b1, 1'b0, rand_data());
         check("rr_seq", 32'(o_grant), 32'(seq[i]));
         check("rr_valid", 32'(o_valid), 32'd1);
      end

      // Single requester 2 with payload A5, then ptr must sit at 3
      step(4'b0000, 1'b1, 1'b1, '0);
      d = rand_data();
      d[2*W +: W] = 8'hA5;
      check("pre_ready", 32'(i_ready), 32'd0);
      step(4'b0100, 1'b1, 1'b0, d);
      check("one_data", 32'(o_data), 32'hA5);
      check("one_grant", 32'(o_grant), 32'd2);
      step(4'b1111, 1'b1, 1'b0, rand_data());
      check("ptr_after2", 32'(o_grant), 32'd3);

      // Back-pressure: hold grant 1 for 5 cycles
      step(4'b0000, 1'b1, 1'b1, '0);
      step(4'b0010, 1'b1, 1'b0, rand_data());
      held = o_data;
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b0, 1'b0, rand_data());
         check("stall_data", 32'(o_data), 32'(held));
         check("stall_grant", 32'(o_grant), 32'd1);
      end
      step(4'b1111, 1'b1, 1'b0, rand_data());
      check("post_stall", 32'(o_grant), 32'd2);

      // Reset while FULL, then lowest valid index wins
      step(4'b1111, 1'b0, 1'b1, rand_data());
      check("midrst_valid", 32'(o_valid), 32'd0);
      check("midrst_grant", 32'(o_grant), 32'd0);
      step(4'b0110, 1'b1, 1'b0, rand_data());
      check("first_after_rst", 32'(o_grant), 32'd1);

      // Toggling 0001/1000 with alternating sink ready
      for (int i = 0; i < 16; i++) begin
         step((i % 2) ? 4'b1000 : 4'b0001, 1'((i + 1) % 2), 1'b0,
              rand_data());
      end

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         step(N'($urandom), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 199) == 0), rand_data());
      end

      // Drain and confirm scoreboard consumed everything
      for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0, rand_data());
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/round_robin_bus_arbiter.md
ROUND_ROBIN_BUS_ARBITER -- requirements
Module: round_robin_bus_arbiter

Interface
REQ-001 The block SHALL have one clock, i_clk, and a synchronous, active-high reset, i_rst, sampled on the rising edge of i_clk.
REQ-002 Parameter N, default 4: number of requesters; legal range 2..16.
REQ-003 Parameter WIDTH, default 8: payload width in bits.
REQ-004 Parameter IDXW, default $clog2(N): width of the grant index; derived, never overridden.
REQ-005 i_clk  in  1  clock.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 i_valid  in  N  per-requester valid; bit k belongs to requester k.
REQ-008 i_ready  out  N  per-requester ready; bit k belongs to requester k.
REQ-009 i_data  in  N*WIDTH  per-requester payload; slice [k*WIDTH +: WIDTH] belongs to requester k.
REQ-010 o_valid  out  1  shared output valid.
REQ-011 o_ready  in  1  shared output ready from the consumer.
REQ-012 o_data  out  WIDTH  registered payload.
REQ-013 o_grant  out  IDXW  index of the requester that supplied o_data.

Function
REQ-014 An input handshake on requester k SHALL occur when i_valid[k] and i_ready[k] are both high at a rising edge.
REQ-015 The output handshake SHALL occur when o_valid and o_ready are both high at a rising edge.
REQ-016 Signal accept SHALL be defined as !o_valid || o_ready (output register empty or draining this cycle).
REQ-017 i_ready SHALL be combinational; at most one bit is high, and bit k is high only when accept and k is the round-robin winner.
REQ-018 Round-robin winner: the first k with i_valid[k] high, searching from index ptr upward modulo N.
REQ-019 ptr SHALL reset to 0; after an input handshake on requester k, ptr SHALL become (k+1) mod N.
REQ-020 On an input handshake on requester k, the next edge SHALL load o_data with slice k of i_data, load o_grant with k, and set o_valid.
REQ-021 On an output handshake with no simultaneous input handshake, o_valid SHALL clear; o_data and o_grant SHALL hold.
REQ-022 When an output handshake and an input handshake occur in the same cycle, the output register SHALL reload (back-to-back), giving 1 beat/cycle throughput.
REQ-023 Latency from input handshake to o_valid SHALL be exactly 1 cycle.
REQ-024 Back-pressure: while o_valid && !o_ready, o_data and o_grant SHALL be stable, all i_ready bits SHALL be 0, and ptr SHALL hold.
REQ-025 States: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-026 Transitions: EMPTY->FULL on input handshake; FULL->EMPTY on output handshake without input handshake; FULL->FULL on input handshake or stall.
REQ-027 No valid requests while accept is high: all i_ready bits SHALL be 0 and ptr SHALL hold.
REQ-028 A requester dropping i_valid before its handshake SHALL NOT be granted.

Reset
REQ-029 Reset values SHALL be: o_valid=0, o_data=0, o_grant=0, ptr=0, all i_ready bits 0.
REQ-030 Reset while FULL SHALL discard the held beat; no output handshake is implied.
REQ-031 While i_rst is high, i_ready SHALL be forced to 0.

Configuration
REQ-032 Macro ROUND_ROBIN_BUS_ARBITER_XFER_COUNT_EN: when defined, the block SHALL add output o_xfer_count (out, 16 bits): count of output handshakes, reset 0, wraps 0xFFFF->0x0000.
REQ-033 When the macro is undefined, o_xfer_count and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Reset, then i_valid=4'b1111, o_ready=1 held -> o_grant sequence 0,1,2,3,0 on consecutive cycles; o_valid high from cycle 1 onward.
REQ-035 i_valid=4'b0100 only, data[2]=8'hA5 -> i_ready=4'b0100; next cycle o_valid=1, o_data=8'hA5, o_grant=2; ptr=3.
REQ-036 FULL with o_grant=1 and o_ready=0 for 5 cycles with i_valid=4'b1111 -> i_ready=0 and o_data stable for all 5 cycles; o_ready=1 -> next grant is 2.
REQ-037 Assert i_rst mid-stream while FULL -> next edge o_valid=0, o_grant=0; first grant after release goes to the lowest valid index from 0.
REQ-038 Macro defined, 65537 output handshakes -> o_xfer_count=1; macro undefined -> design builds with no o_xfer_count port.
REQ-039 i_valid toggles 4'b0001 and 4'b1000 with o_ready alternating 1/0 -> every accepted payload appears on o_data exactly once, in grant order.
